// File: rtl/dpi_pkt_sequencer_if.sv
// rtl/dpi_pkt_sequencer_if.sv - ingress beat bus between the packet buffer and the sequencer
interface dpi_pkt_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic [5:0] in_stream_id;

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_stream_id,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_stream_id,
    output in_ready
  );
endinterface

// File: rtl/dpi_pkt_sequencer.sv
// rtl/dpi_pkt_sequencer.sv - matcher-bank packet sequencer; optional counters under DPI_SEQ_STATS_EN
module dpi_pkt_sequencer #(
  parameter int NUM_REGEX    = 8,
  parameter int LOAD_GAP     = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  dpi_pkt_sequencer_if.slave   in_if,
  input  logic                 cfg_we,
  input  logic [5:0]           cfg_addr,
  input  logic [NUM_REGEX-1:0] cfg_data,
  input  logic                 clear_seen,
  output logic                 load_state,
  output logic [5:0]           stream_id,
  output logic                 new_stream_id,
  output logic [NUM_REGEX-1:0] enable,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic                 drop_err,
  output logic [31:0]          pkt_count,
  output logic [31:0]          byte_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP} state_t;

  // The registered char stage supplies one idle cycle, so GAP holds LOAD_GAP-1 cycles.
  localparam logic [7:0] GAP_LAST  = 8'(LOAD_GAP - 2);
  localparam logic [7:0] DRAIN_SAT = 8'(DRAIN_CYCLES);

  state_t               state_q, state_d;
  logic [7:0]           gap_cnt_q, gap_cnt_d;
  logic [7:0]           idle_cnt_q, idle_cnt_d;
  logic                 got_first_q, got_first_d;
  logic [5:0]           stream_id_q, stream_id_d;
  logic [NUM_REGEX-1:0] enable_q, enable_d;
  logic                 new_q, new_d;
  logic [7:0]           char_q, char_d;
  logic                 char_vld_q, char_vld_d;
  logic [63:0]          seen_q;
  logic [NUM_REGEX-1:0] tbl_q [64];
  logic                 in_ready_c;
  logic                 drop_c;
  logic                 load_c;
  logic                 eop_c;

  // Next-state and handshake decode; idle_cnt counts cycles since the last char_in_vld.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    got_first_d = got_first_q;
    stream_id_d = stream_id_q;
    enable_d    = enable_q;
    new_d       = new_q;
    char_d      = char_q;
    char_vld_d  = 1'b0;
    in_ready_c  = 1'b0;
    drop_c      = 1'b0;
    load_c      = 1'b0;
    eop_c       = 1'b0;
    if (char_vld_q) begin
      idle_cnt_d = 8'd0;
    end else if (idle_cnt_q >= DRAIN_SAT) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_if.in_valid) begin
          if (in_if.in_sop) begin
            // The sop beat stays on the bus; it is consumed as the first STREAM beat.
            stream_id_d = in_if.in_stream_id;
            enable_d    = tbl_q[in_if.in_stream_id];
            new_d       = ~seen_q[in_if.in_stream_id];
            state_d     = S_LOAD;
          end else begin
            in_ready_c = 1'b1;
            drop_c     = 1'b1;
          end
        end
      end
      S_LOAD: begin
        load_c      = 1'b1;
        got_first_d = 1'b0;
        gap_cnt_d   = 8'd0;
        state_d     = (LOAD_GAP > 1) ? S_GAP : S_STREAM;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == GAP_LAST) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (in_if.in_valid && in_if.in_sop && got_first_q) begin
          // A second sop closes the current packet without being consumed.
          state_d = S_DRAIN;
        end else begin
          in_ready_c = 1'b1;
          if (in_if.in_valid) begin
            char_d      = in_if.in_data;
            char_vld_d  = 1'b1;
            got_first_d = 1'b1;
            if (in_if.in_eop) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (idle_cnt_d >= DRAIN_SAT) state_d = S_EOP;
      end
      S_EOP: begin
        eop_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      in_ready_c = 1'b0;
      drop_c     = 1'b0;
    end
  end

  // FSM state and per-packet context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      got_first_q <= 1'b0;
      stream_id_q <= '0;
      enable_q    <= '0;
      new_q       <= 1'b0;
      char_q      <= '0;
      char_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      got_first_q <= got_first_d;
      stream_id_q <= stream_id_d;
      enable_q    <= enable_d;
      new_q       <= new_d;
      char_q      <= char_d;
      char_vld_q  <= char_vld_d;
    end
  end

  // Enable table writes and seen tracking; clear_seen beats the eop set.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= '0;
      for (int i = 0; i < 64; i++) tbl_q[i] <= '0;
    end else begin
      if (cfg_we) tbl_q[cfg_addr] <= cfg_data;
      if (clear_seen) begin
        seen_q <= '0;
      end else if (state_q == S_EOP) begin
        seen_q[stream_id_q] <= 1'b1;
      end
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign drop_err       = drop_c;
  assign load_state     = load_c;
  assign eop            = eop_c;
  assign stream_id      = stream_id_q;
  assign enable         = enable_q;
  assign new_stream_id  = new_q;
  assign char_in        = char_q;
  assign char_in_vld    = char_vld_q;

`ifdef DPI_SEQ_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] byte_cnt_q;

  // Free-running packet and byte counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      if (eop_c)      pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (char_vld_q) byte_cnt_q <= byte_cnt_q + 32'd1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign byte_count = byte_cnt_q;
`else
  assign pkt_count  = 32'd0;
  assign byte_count = 32'd0;
`endif

endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// tb/tb_dpi_pkt_sequencer.sv - self-checking bench for dpi_pkt_sequencer
module tb_dpi_pkt_sequencer;
  localparam int LGAP  = 2;
  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpi_pkt_sequencer_if bus();
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        clear_seen = 1'b0;
  logic        load_state, new_stream_id, char_in_vld, eop, drop_err;
  logic [5:0]  stream_id;
  logic [7:0]  enable, char_in;
  logic [31:0] pkt_count, byte_count;

  dpi_pkt_sequencer #(.NUM_REGEX(8), .LOAD_GAP(LGAP), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .in_if(bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .clear_seen(clear_seen),
    .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
    .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
    .drop_err(drop_err), .pkt_count(pkt_count), .byte_count(byte_count)
  );

  typedef struct {logic [5:0] id; logic nw; logic [7:0] en; int cyc;} ev_t;
  typedef struct {logic [5:0] id; logic nw; logic [7:0] en; int n;} exp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  ev_t        ld_q[$];
  ev_t        eop_q[$];
  logic [7:0] ch_q[$];
  int         chc_q[$];
  int         drop_n = 0;
  int         stab_err = 0;
  bit         active = 0;
  logic [5:0] act_id;
  logic [7:0] act_en;

  logic       seen_m [64];
  logic [7:0] tbl_m [64];
  exp_t       exp_q[$];
  logic [7:0] exp_ch[$];
  int         pkt_m = 0;
  int         byte_m = 0;
  int         fixb = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe matcher-side events away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else begin
      if (int'(load_state) + int'(char_in_vld) + int'(eop) > 1) stab_err++;
      if (load_state) begin
        ld_q.push_back('{stream_id, new_stream_id, enable, cyc});
        active = 1; act_id = stream_id; act_en = enable;
      end else if (active && (stream_id !== act_id || enable !== act_en)) begin
        stab_err++;
      end
      if (char_in_vld) begin ch_q.push_back(char_in); chc_q.push_back(cyc); end
      if (eop) begin eop_q.push_back('{stream_id, new_stream_id, enable, cyc}); active = 0; end
      if (drop_err) drop_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin seen_m[i] = 1'b0; tbl_m[i] = 8'h00; end
    pkt_m = 0; byte_m = 0;
  endtask

  task automatic clear_obs();
    ld_q.delete(); eop_q.delete(); ch_q.delete(); chc_q.delete();
    exp_q.delete(); exp_ch.delete(); stab_err = 0;
  endtask

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic drive_beat(input logic [7:0] d, input bit s, input bit e, input logic [5:0] id);
    bit acc;
    acc = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sop = s; bus.in_eop = e; bus.in_stream_id = id;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    if (!acc) chk("beat_accept", acc, 1);
  endtask

  // wr_mode: 0 none, 1 write own id after beat 1, 2 write own id on the sop-sampling edge.
  task automatic send(input logic [5:0] id, input int n, input bit with_eop, input bit gaps,
                      input int wr_mode, input logic [7:0] wr_data);
    exp_t e;
    logic [7:0] b;
    e.id = id; e.nw = !seen_m[id]; e.en = tbl_m[id]; e.n = n;
    exp_q.push_back(e);
    seen_m[id] = 1'b1; pkt_m++; byte_m += n;
    if (wr_mode == 2) begin
      cfg_we = 1'b1; cfg_addr = id; cfg_data = wr_data; tbl_m[id] = wr_data;
      fork begin @(posedge clk); #1; cfg_we = 1'b0; end join_none
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) step($urandom_range(0, 2));
      b = (fixb >= 0) ? 8'(fixb) : 8'($urandom);
      exp_ch.push_back(b);
      drive_beat(b, i == 0, with_eop && i == n - 1, id);
      if (wr_mode == 1 && i == 1) cfg_write(id, wr_data);
    end
  endtask

  task automatic finish_pkts();
    int k;
    int off;
    int mism;
    k = 0;
    while (eop_q.size() < exp_q.size() && k < 300) begin step(1); k++; end
    step(3);
    chk("n_load", ld_q.size(), exp_q.size());
    chk("n_eop", eop_q.size(), exp_q.size());
    chk("n_char", ch_q.size(), exp_ch.size());
    chk("stable_onehot", stab_err, 0);
    if (ld_q.size() == exp_q.size() && eop_q.size() == exp_q.size() && ch_q.size() == exp_ch.size()) begin
      mism = 0;
      foreach (exp_ch[i]) if (ch_q[i] !== exp_ch[i]) mism++;
      chk("char_bytes", mism, 0);
      off = 0;
      foreach (exp_q[p]) begin
        chk("load_id", ld_q[p].id, exp_q[p].id);
        chk("new_stream_id", ld_q[p].nw, exp_q[p].nw);
        chk("enable", ld_q[p].en, exp_q[p].en);
        chk("eop_id", eop_q[p].id, exp_q[p].id);
        chk("load_to_char", chc_q[off] - ld_q[p].cyc, LGAP + 1);
        chk("char_to_eop", eop_q[p].cyc - chc_q[off + exp_q[p].n - 1], DRAIN + 1);
        off += exp_q[p].n;
      end
    end
    clear_obs();
  endtask

  initial begin
    int d0;
    int k;
    int n;
    bit we;
    bit prev_done;
    int wm;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_stream_id = '0;
    model_reset();
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {load_state, char_in_vld, eop, drop_err, new_stream_id, bus.in_ready,
                       stream_id, enable, char_in}, 0);
    chk("reset_stats", {pkt_count, byte_count}, 0);
    @(posedge clk); #1;
    clear_obs();

    // New id then repeat id.
    send(6'd5, 4, 1, 0, 0, 8'h00); finish_pkts();
    send(6'd5, 4, 1, 0, 0, 8'h00); finish_pkts();

    // Enable table: mid-packet write deferred to next packet; same-edge write uses old value.
    cfg_write(6'd5, 8'hA5);
    send(6'd5, 6, 1, 0, 1, 8'h0F); finish_pkts();
    send(6'd5, 3, 1, 1, 2, 8'h3C); finish_pkts();
    send(6'd5, 2, 1, 0, 0, 8'h00); finish_pkts();

    // Single-byte packet, then a bubbly packet.
    fixb = 8'h41;
    send(6'd7, 1, 1, 0, 0, 8'h00); finish_pkts();
    fixb = -1;
    send(6'd3, 8, 1, 1, 0, 8'h00); finish_pkts();

    // Orphan beats in IDLE.
    d0 = drop_n;
    drive_beat(8'h11, 0, 0, 6'd0);
    drive_beat(8'h22, 0, 1, 6'd0);
    step(3);
    chk("orphan_drops", drop_n - d0, 2);
    chk("orphan_no_load", ld_q.size(), 0);
    clear_obs();

    // clear_seen coincident with eop of id 9.
    send(6'd9, 2, 1, 0, 0, 8'h00); finish_pkts();
    send(6'd9, 3, 1, 0, 0, 8'h00);
    k = 0;
    while (!eop && k < 100) begin @(negedge clk); k++; end
    clear_seen = 1'b1;
    @(posedge clk); #1;
    clear_seen = 1'b0;
    for (int i = 0; i < 64; i++) seen_m[i] = 1'b0;
    finish_pkts();
    send(6'd9, 2, 1, 0, 0, 8'h00); finish_pkts();

    // Implicit eop from a sop inside STREAM.
    send(6'd11, 3, 0, 0, 0, 8'h00);
    send(6'd12, 2, 1, 0, 0, 8'h00); finish_pkts();

    // Randomized packets against the model.
    prev_done = 1;
    for (int p = 0; p < 14; p++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(6'($urandom_range(0, 7)), 8'($urandom));
      n = $urandom_range(1, 12);
      we = (p == 13) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wm = $urandom_range(0, prev_done ? 2 : 1);
      send(6'($urandom_range(0, 7)), n, we, $urandom_range(0, 1) == 1, wm, 8'($urandom));
      if (we) finish_pkts();
      prev_done = we;
    end

    // Reset in the middle of a packet.
    drive_beat(8'h01, 1, 0, 6'd20);
    drive_beat(8'h02, 0, 0, 6'd20);
    drive_beat(8'h03, 0, 0, 6'd20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {load_state, char_in_vld, eop, drop_err, new_stream_id, bus.in_ready,
                        stream_id, enable}, 0);
    chk("midrst_stats", {pkt_count, byte_count}, 0);
    @(posedge clk); #1;
    clear_obs();
    model_reset();
    d0 = drop_n;
    drive_beat(8'h04, 0, 1, 6'd20);
    step(8);
    chk("midrst_orphan", drop_n - d0, 1);
    chk("midrst_no_eop", eop_q.size(), 0);
    chk("midrst_no_load", ld_q.size(), 0);
    clear_obs();

    // Counter run: 10, 1 and 64 bytes after reset.
    send(6'd1, 10, 1, 0, 0, 8'h00); finish_pkts();
    send(6'd2, 1, 1, 0, 0, 8'h00); finish_pkts();
    send(6'd1, 64, 1, 0, 0, 8'h00); finish_pkts();
`ifdef DPI_SEQ_STATS_EN
    chk("pkt_count", pkt_count, pkt_m);
    chk("byte_count", byte_count, byte_m);
`else
    chk("pkt_count", pkt_count, 0);
    chk("byte_count", byte_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
